// File: rtl/div_pkg.sv
// Shared types and constants for the divider-sharing controller.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } div_state_t;

  localparam int DEF_DIV_LATENCY = 5;

  // Divide-by-zero answer: all-ones quotient, remainder echoes the dividend.
  localparam logic [3:0] DZ_QUOT = 4'hF;
  localparam logic [3:0] DZ_DIVISOR = 4'h0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one external divider among NUM_REQ requesters; one transaction in
// flight, round-robin grant, divide-by-zero answered locally.
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_dividend,
  input  logic [4*NUM_REQ-1:0] req_divisor,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_quotient,
  output logic [4:0]           rsp_remainder,
  output logic                 rsp_dz,
  output logic                 busy,
  output logic                 div_start,
  output logic [3:0]           div_Q,
  output logic [3:0]           div_M,
  input  logic [3:0]           div_Q_product,
  input  logic [4:0]           div_R_product
);

  div_state_t state, state_nxt;

  logic [NUM_REQ-1:0][3:0] dvd_a, dvs_a;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [ID_W-1:0]         arb_idx, rr_ptr, cur_id;
  logic                    arb_any;
  logic [3:0]              arb_q, arb_m;
  logic [CNT_W-1:0]        cnt;

  assign dvd_a = req_dividend;
  assign dvs_a = req_divisor;
  assign arb_q = dvd_a[arb_idx];
  assign arb_m = dvs_a[arb_idx];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|req) state_nxt = ARB;
      ARB: begin
        if (!arb_any)                 state_nxt = IDLE;
        else if (arb_m == DZ_DIVISOR) state_nxt = RESP;
        else                          state_nxt = START;
      end
      START: state_nxt = WAIT;
      WAIT:  if (cnt == '0) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign div_start = (state == START);
  assign rsp_valid = (state == RESP);

  // Response fields only change on entry to RESP so they hold between answers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gnt           <= '0;
      rr_ptr        <= '0;
      cur_id        <= '0;
      cnt           <= '0;
      div_Q         <= '0;
      div_M         <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dz        <= 1'b0;
    end else begin
      case (state)
        ARB: if (arb_any) begin
          gnt    <= arb_gnt;
          cur_id <= arb_idx;
          div_Q  <= arb_q;
          div_M  <= arb_m;
          rr_ptr <= (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
          if (arb_m == DZ_DIVISOR) begin
            rsp_id        <= arb_idx;
            rsp_quotient  <= DZ_QUOT;
            rsp_remainder <= {1'b0, arb_q};
            rsp_dz        <= 1'b1;
          end
        end
        START: cnt <= CNT_W'(DIV_LATENCY-1);
        WAIT: begin
          if (cnt == '0) begin
            rsp_id        <= cur_id;
            rsp_quotient  <= div_Q_product;
            rsp_remainder <= div_R_product;
            rsp_dz        <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural latency-accurate divider.
module tb_div_share_ctrl;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 5;
  localparam int CNT_W   = 3;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ-1:0][3:0] dvd = '0, dvs = '0;
  logic [NUM_REQ-1:0]      gnt;
  logic                    rsp_valid, rsp_dz, busy, div_start;
  logic [ID_W-1:0]         rsp_id;
  logic [3:0]              rsp_quotient, div_Q, div_M, div_Q_product;
  logic [4:0]              rsp_remainder, div_R_product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIV_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_dividend(dvd), .req_divisor(dvs),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz), .busy(busy), .div_start(div_start),
    .div_Q(div_Q), .div_M(div_M), .div_Q_product(div_Q_product), .div_R_product(div_R_product)
  );

  // Divider model: products become correct LAT-1 edges after start is sampled,
  // i.e. in the cycle ending LAT edges after start; junk before that.
  int  dk;
  logic dact;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dact <= 1'b0;
      dk   <= 0;
    end else if (div_start) begin
      dact <= 1'b1;
      dk   <= 0;
    end else if (dact && dk < 1000) begin
      dk <= dk + 1;
    end
  end
  wire prod_ok = dact && (dk >= LAT-1) && (div_M != 4'd0);
  assign div_Q_product = prod_ok ? div_Q / div_M : 4'hA;
  assign div_R_product = prod_ok ? {1'b0, div_Q % div_M} : 5'h1F;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'd0);
    check({tag, "_vld"},  32'(rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_strt"}, 32'(div_start), 32'd0);
    check({tag, "_dQ"},   32'(div_Q), 32'd0);
    check({tag, "_dM"},   32'(div_M), 32'd0);
    check({tag, "_id"},   32'(rsp_id), 32'd0);
    check({tag, "_quo"},  32'(rsp_quotient), 32'd0);
    check({tag, "_rem"},  32'(rsp_remainder), 32'd0);
    check({tag, "_dz"},   32'(rsp_dz), 32'd0);
  endtask

  // Single-requester transaction; n counts the ARB cycle as cycle 1.
  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [4:0] er, input logic edz);
    int  n;
    bit  got;
    int  elat;
    elat = edz ? 2 : LAT + 3;
    @(negedge clk);
    dvd[id] = a;
    dvs[id] = b;
    req = '0;
    req[id] = 1'b1;
    @(negedge clk);
    n = 1;
    got = 0;
    check("busy_arb", 32'(busy), 32'd1);
    while (!got && n < 40) begin
      check("div_start", 32'(div_start), 32'(n == 2 && !edz));
      if (!edz && n >= 3 && !rsp_valid) begin
        check("wait_dQ", 32'(div_Q), 32'(a));
        check("wait_dM", 32'(div_M), 32'(b));
      end
      if (rsp_valid) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("latency",  32'(n), 32'(elat));
    check("rsp_id",   32'(rsp_id), 32'(id));
    check("rsp_quo",  32'(rsp_quotient), 32'(eq));
    check("rsp_rem",  32'(rsp_remainder), 32'(er));
    check("rsp_dz",   32'(rsp_dz), 32'(edz));
    check("rsp_gnt",  32'(gnt), 32'(1 << id));
    req = '0;
    @(negedge clk);
    check("post_vld",  32'(rsp_valid), 32'd0);
    check("post_gnt",  32'(gnt), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("hold_quo",  32'(rsp_quotient), 32'(eq));
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [4:0] r;
    logic       dz;
  } vec_t;

  vec_t vt[7];

  initial begin
    int k, n;
    bit got, seen;
    int         ord_id[5];
    logic [3:0] eq3[4];
    logic [4:0] er3[4];

    vt[0] = '{0, 4'd15, 4'd11, 4'd1,  5'd4, 1'b0};
    vt[1] = '{2, 4'd7,  4'd2,  4'd3,  5'd1, 1'b0};
    vt[2] = '{1, 4'd9,  4'd0,  4'd15, 5'd9, 1'b1};
    vt[3] = '{3, 4'd0,  4'd5,  4'd0,  5'd0, 1'b0};
    vt[4] = '{1, 4'd15, 4'd1,  4'd15, 5'd0, 1'b0};
    vt[5] = '{2, 4'd3,  4'd7,  4'd0,  5'd3, 1'b0};
    vt[6] = '{0, 4'd0,  4'd0,  4'd15, 5'd0, 1'b1};

    ord_id = '{0, 1, 2, 3, 0};
    eq3    = '{4'd3, 4'd2, 4'd2, 4'd1};
    er3    = '{5'd0, 5'd0, 5'd3, 5'd0};

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // All four requesting: served 0,1,2,3,0 from a fresh pointer
    dvd = '{4'd6, 4'd13, 4'd8, 4'd9};
    dvs = '{4'd6, 4'd5,  4'd4, 4'd3};
    req = 4'b1111;
    k = 0;
    n = 0;
    while (k < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        check("rr_id",  32'(rsp_id), 32'(ord_id[k]));
        check("rr_quo", 32'(rsp_quotient), 32'(eq3[ord_id[k]]));
        check("rr_rem", 32'(rsp_remainder), 32'(er3[ord_id[k]]));
        k++;
      end
    end
    req = '0;
    check("rr_count", 32'(k), 32'd5);
    @(negedge clk);

    // Single-requester vectors
    for (int i = 0; i < 7; i++)
      run_one(vt[i].id, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

    // Requester 3 drops req the cycle after its grant
    @(negedge clk);
    dvd[3] = 4'd14;
    dvs[3] = 4'd4;
    req = 4'b1000;
    n = 0;
    while (!gnt[3] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drop_gnt", 32'(gnt), 32'b1000);
    @(negedge clk);
    req = '0;
    dvd[3] = 4'd1;
    dvs[3] = 4'd1;
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1;
    end
    check("drop_seen", 32'(got), 32'd1);
    check("drop_id",   32'(rsp_id), 32'd3);
    check("drop_quo",  32'(rsp_quotient), 32'd3);
    check("drop_rem",  32'(rsp_remainder), 32'd2);
    @(negedge clk);
    run_one(0, 4'd5, 4'd2, 4'd2, 5'd1, 1'b0);

    // Reset during WAIT abandons the transaction and rewinds the pointer
    dvd[0] = 4'd10;
    dvs[0] = 4'd3;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check_all_zero("midrst");
    req = '0;
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("no_rsp_after_rst", 32'(seen), 32'd0);
    dvd[0] = 4'd12;
    dvs[0] = 4'd5;
    dvd[1] = 4'd7;
    dvs[1] = 4'd7;
    req = 4'b0011;
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid) got = 1;
    end
    req = '0;
    check("rst_seen", 32'(got), 32'd1);
    check("rst_id",   32'(rsp_id), 32'd0);
    check("rst_quo",  32'(rsp_quotient), 32'd2);
    check("rst_rem",  32'(rsp_remainder), 32'd2);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
